// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU. It answers the hazard unit's
// div_start/div_ready handshake and returns {remainder, quotient}.
module div_unit #(
    parameter int DIV_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_start,
    input  logic                 div_signed,
    input  logic [DIV_W-1:0]     opdata1,
    input  logic [DIV_W-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*DIV_W-1:0]   result,
    output logic                 div_ready
);

    localparam int CNT_W = $clog2(DIV_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [DIV_W-1:0]     rem_r;
    logic [DIV_W-1:0]     dvd_r;
    logic [DIV_W-1:0]     dvs_r;
    logic                 q_neg_r;
    logic                 r_neg_r;
    logic [DIV_W:0]       shifted_s;
    logic [DIV_W:0]       diff_s;
    logic [2*DIV_W-1:0]   result_s;
    logic                 done_s;

    // Two's complement negation, wrapping at DIV_W bits.
    function automatic logic [DIV_W-1:0] neg2c(input logic [DIV_W-1:0] v);
        return ~v + {{(DIV_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v, input logic sgn);
        return (sgn && v[DIV_W-1]) ? neg2c(v) : v;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; annul/withdrawn start abandon a busy division.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_start && !annul) begin
                    state_s = (opdata2 == {DIV_W{1'b0}}) ? DIVZERO : BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (annul || !div_start) begin
                    state_s = IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DIVZERO: state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output/datapath combinational terms: trial subtraction and signed fix-up.
    always_comb begin
        shifted_s = {rem_r, dvd_r[DIV_W-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        result_s  = {(r_neg_r ? neg2c(rem_r) : rem_r),
                     (q_neg_r ? neg2c(dvd_r) : dvd_r)};
        done_s    = (state_r == DONE);
    end

    // Datapath: operand capture, one quotient bit per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            rem_r   <= {DIV_W{1'b0}};
            dvd_r   <= {DIV_W{1'b0}};
            dvs_r   <= {DIV_W{1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (state_s == BUSY) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        rem_r   <= {DIV_W{1'b0}};
                        dvd_r   <= mag(opdata1, div_signed);
                        dvs_r   <= mag(opdata2, div_signed);
                        q_neg_r <= div_signed & (opdata1[DIV_W-1] ^ opdata2[DIV_W-1]);
                        r_neg_r <= div_signed & opdata1[DIV_W-1];
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                BUSY: begin
                    if (state_s != IDLE) begin
                        if (!diff_s[DIV_W]) begin
                            rem_r <= diff_s[DIV_W-1:0];
                            dvd_r <= {dvd_r[DIV_W-2:0], 1'b1};
                        end else begin
                            rem_r <= shifted_s[DIV_W-1:0];
                            dvd_r <= {dvd_r[DIV_W-2:0], 1'b0};
                        end
                        cnt_r <= (cnt_r == LAST_CNT) ? cnt_r : cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                DIVZERO: begin
                    rem_r   <= {DIV_W{1'b0}};
                    dvd_r   <= {DIV_W{1'b0}};
                    q_neg_r <= 1'b0;
                    r_neg_r <= 1'b0;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered outputs: result is committed together with the ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_ready <= 1'b0;
            result    <= {(2*DIV_W){1'b0}};
        end else begin
            div_ready <= done_s;
            if (done_s) begin
                result <= result_s;
            end else begin
                result <= result;
            end
        end
    end

endmodule
